// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types and constants for the 16-bit core front end.
//   ifs_t           fetch unit state (IDLE, RUN, HALT)
//   IFETCH_RESET_PC default program counter after reset
//   fetch_entry_t   one prefetch queue entry {pc, ins}
package mycpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifs_t;

  localparam logic [15:0] IFETCH_RESET_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: prefetch queue of fetch_entry_t, FIFO_DEPTH entries (power of two).
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push_i/push_data_i  write an entry (ignored when full or clearing)
//   pop_i          drop the head entry (ignored when empty or clearing)
//   clear_i        empty the queue; takes priority over push and pop
//   head_o         oldest entry
//   count_o        number of valid entries
//   empty_o/full_o status flags
module ifetch_fifo
  import mycpu_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] RESET_PC   = IFETCH_RESET_PC,
  localparam int         AW         = $clog2(FIFO_DEPTH),
  localparam int         CW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_entry_t  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_push = push_i && !clear_i && !full_o;
  assign do_pop  = pop_i && !clear_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Clear moves the write pointer onto the read pointer instead of zeroing
  // both, so the head (and the IR-facing word) does not change on a flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '{pc: RESET_PC, ins: 16'h0000};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Owns the fetch PC, issues word reads to
// instruction memory under a credit limit, buffers returned words in a
// prefetch queue and hands them to the IR as a load strobe plus word.
// Redirects flush the queue and mark all in-flight responses as stale.
//
// Valid/ready: a memory request transfers when imem_req && imem_gnt in the
// same cycle; imem_rvalid is a one-cycle, in-order response with no back
// pressure; a queue word transfers to the IR when il_out is high (il_out
// already includes ir_ready), and it is popped in that same cycle.
//
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   halt_in                 stop issuing requests (queue keeps draining)
//   redirect_en/_addr       one-cycle control-flow redirect
//   imem_req/addr/gnt       request channel
//   imem_rvalid/rdata       response channel
//   ir_ready                IR can take a word
//   il_out/ins_out/pc_out   word to the IR and its address
//   perf_fetch_cnt/perf_drop_cnt  only when IFETCH_PERF_EN is defined
//   dbg_state               current ifs_t state
// Optional feature macro: IFETCH_PERF_EN.
module ifetch
  import mycpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = IFETCH_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_in,
  input  logic        redirect_en,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        ir_ready,
  output logic        il_out,
  output logic [15:0] ins_out,
  output logic [15:0] pc_out,
`ifdef IFETCH_PERF_EN
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_drop_cnt,
`endif
  output logic [1:0]  dbg_state
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  ifs_t          state_q;
  logic [15:0]   fetch_pc_q;
  logic [15:0]   resp_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] outst_d;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] drop_d;

  fetch_entry_t  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;

  logic          rv_ok;
  logic          grant;
  logic          discard;
  logic [CW:0]   inflight;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv_ok    = imem_rvalid && (outst_q != '0);
  assign inflight = {1'b0, outst_q} + {1'b0, fifo_count};

  assign imem_req  = (state_q == RUN) && !redirect_en && (inflight < DEPTH_W);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  assign fifo_push = rv_ok && !redirect_en && (drop_q == '0) && !fifo_full;
  assign discard   = rv_ok && (redirect_en || (drop_q != '0));

  assign il_out    = !fifo_empty && ir_ready && !redirect_en;
  assign ins_out   = fifo_head.ins;
  assign pc_out    = fifo_head.pc;
  assign dbg_state = state_q;

  ifetch_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .RESET_PC   (RESET_PC)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ('{pc: resp_pc_q, ins: imem_rdata}),
    .pop_i       (il_out),
    .clear_i     (redirect_en),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    state_q <= halt_in ? HALT : RUN;
        RUN:     state_q <= halt_in ? HALT : RUN;
        HALT:    state_q <= halt_in ? HALT : RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stale responses stay in the outstanding count until they return, so the
  // credit limit still covers them; drop_cnt just says how many to discard.
  always_comb begin
    outst_d = outst_q;
    drop_d  = drop_q;
    case ({grant, rv_ok})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    if (redirect_en) begin
      drop_d = outst_q - {{(CW-1){1'b0}}, rv_ok};
    end else if (rv_ok && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      if (redirect_en) begin
        fetch_pc_q <= redirect_addr;
        resp_pc_q  <= redirect_addr;
      end else begin
        if (grant)     fetch_pc_q <= fetch_pc_q + 16'd1;
        if (fifo_push) resp_pc_q  <= resp_pc_q + 16'd1;
      end
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch_q;
  logic [15:0] perf_drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= 16'h0000;
      perf_drop_q  <= 16'h0000;
    end else begin
      if (il_out && (perf_fetch_q != 16'hFFFF)) perf_fetch_q <= perf_fetch_q + 16'd1;
      if (discard && (perf_drop_q != 16'hFFFF)) perf_drop_q  <= perf_drop_q + 16'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_drop_cnt  = perf_drop_q;
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized bench for ifetch with an in-order memory model and a
// scoreboard. The reference model only knows the architectural rules: words
// come out in fetch order starting at the reset PC or the last redirect
// target, word(a) = a ^ 16'hA5A5, and at most FIFO_DEPTH words are in flight
// (granted but not yet delivered or discarded).
module tb_ifetch;
  import mycpu_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [15:0] RPC   = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt_in = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_addr = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        ir_ready = 1'b0;
  logic        il_out;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic [1:0]  dbg_state;
`ifdef IFETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  ifetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .halt_in       (halt_in),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .ir_ready      (ir_ready),
    .il_out        (il_out),
    .ins_out       (ins_out),
    .pc_out        (pc_out),
`ifdef IFETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt (perf_drop_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    int          due;
    logic [15:0] addr;
    bit          live;
  } pend_t;

  pend_t       pend_q[$];   // granted requests whose response has not returned
  logic [31:0] exp_q[$];    // {pc, ins} expected on the IR side, in order
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          in_reset = 1'b1;
  int          tb_queued = 0;
  int          first_il = -1;
  int          delivered = 0;
  int          drops = 0;
  logic [15:0] model_pc = RPC;
  bit          prev_halt = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  function automatic int live_pending();
    int n = 0;
    foreach (pend_q[i]) if (pend_q[i].live) n++;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    in_reset      = 1'b1;
    rst           = 1'b1;
    halt_in       = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = 16'h0000;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 16'h0000;
    ir_ready      = 1'b1;
    #1;
    chk("rst_il_out",   il_out,    0);
    chk("rst_imem_req", imem_req,  0);
    chk("rst_imem_addr", imem_addr, RPC);
    chk("rst_pc_out",   pc_out,    RPC);
    chk("rst_ins_out",  ins_out,   16'h0000);
    chk("rst_state",    dbg_state, IDLE);
`ifdef IFETCH_PERF_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 0);
    chk("rst_perf_drop",  perf_drop_cnt,  0);
`endif
    pend_q.delete();
    exp_q.delete();
    model_pc  = RPC;
    prev_halt = 1'b0;
    tb_queued = 0;
    first_il  = -1;
    delivered = 0;
    drops     = 0;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    cyc      = 0;
    in_reset = 1'b0;
  endtask

  // One clock of stimulus. Inputs change on the falling edge; outputs are
  // sampled 1 time unit later, then the model books what the next rising
  // edge will do.
  task automatic cycle_step(input bit g, input int lat, input bit rdy, input bit hlt,
                            input bit redir, input logic [15:0] raddr);
    bit    rv;
    bit    exp_req;
    pend_t p;
    @(negedge clk);
    cyc++;
    rv            = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    imem_rvalid   = rv;
    imem_rdata    = rv ? mem_word(pend_q[0].addr) : 16'h0000;
    imem_gnt      = g;
    ir_ready      = rdy;
    halt_in       = hlt;
    redirect_en   = redir;
    redirect_addr = raddr;
    #1;
    tb_queued = exp_q.size() - live_pending();
    exp_req   = (cyc >= 1) && !prev_halt && !redir && ((pend_q.size() + tb_queued) < DEPTH);
    chk("imem_req", imem_req, exp_req);
    if (imem_req && exp_req) chk("imem_addr", imem_addr, model_pc);
    if (imem_req && g) begin
      p.due  = cyc + lat;
      p.addr = imem_addr;
      p.live = 1'b1;
      pend_q.push_back(p);
      exp_q.push_back({model_pc, mem_word(model_pc)});
      model_pc = model_pc + 16'd1;
    end
    if (redir) begin
      foreach (pend_q[i]) pend_q[i].live = 1'b0;
      exp_q.delete();
      model_pc = raddr;
    end
    if (rv) begin
      p = pend_q.pop_front();
      if (!p.live) drops++;
    end
    prev_halt = hlt;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [31:0] e;
    bit          exp_il;
    forever begin
      @(negedge clk);
      #2;
      if (!in_reset && !rst) begin
        exp_il = (tb_queued > 0) && ir_ready && !redirect_en;
        chk("il_out", il_out, exp_il);
        if (il_out) begin
          if (first_il < 0) first_il = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow cyc=%0d actual pc=%h expected no word", cyc, pc_out);
          end else begin
            e = exp_q.pop_front();
            chk("pc_out",  pc_out,  e[31:16]);
            chk("ins_out", ins_out, e[15:0]);
            delivered++;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          done;
    bit          r;
    bit          hlt;
    logic [15:0] ra;
    #2;
    apply_reset();

    // Zero-wait memory, IR always ready.
    repeat (40) cycle_step(1'b1, 1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("first_il_cycle", first_il, 3);

    // IR stall for 5 cycles, then resume.
    repeat (5)  cycle_step(1'b1, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (10) cycle_step(1'b1, 1, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Latency-3 memory, redirect to 0100 once two requests are in flight.
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      r = !done && (pend_q.size() == 2);
      cycle_step(1'b1, 3, 1'b1, 1'b0, r, 16'h0100);
      if (r) done = 1'b1;
    end
    chk("redirect_taken", done, 1);
`ifdef IFETCH_PERF_EN
    chk("perf_drop_after_redirect", perf_drop_cnt, 2);
`endif

    // Redirect near the top of the address space to exercise wrap.
    cycle_step(1'b1, 1, 1'b1, 1'b0, 1'b1, 16'hFFFD);
    repeat (12) cycle_step(1'b1, 1, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Halt mid-stream, then resume.
    repeat (2) cycle_step(1'b1, 1, 1'b1, 1'b1, 1'b0, 16'h0000);
    chk("halt_state", dbg_state, HALT);
    repeat (6)  cycle_step(1'b1, 1, 1'b1, 1'b1, 1'b0, 16'h0000);
    repeat (10) cycle_step(1'b1, 1, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Random grant, latency, IR readiness, halts and redirects.
    hlt = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 4);
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      if ($urandom_range(0, 99) < 8) hlt = !hlt;
      cycle_step($urandom_range(0, 9) < 7, $urandom_range(1, 4),
                 $urandom_range(0, 9) < 7, hlt, r, ra);
    end

    // Fill the queue with the IR stalled, then reset with IR ready.
    repeat (8) cycle_step(1'b1, 1, 1'b0, 1'b0, 1'b0, 16'h0000);
    #2;
    in_reset = 1'b1;
    ir_ready = 1'b1;
    #1;
    chk("prerst_il_out", il_out, (tb_queued > 0));
    chk("prerst_queue_full", tb_queued, DEPTH);
    apply_reset();
    repeat (20) cycle_step(1'b1, 1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("post_reset_first_il", first_il, 3);

    @(negedge clk);
    in_reset = 1'b1;
`ifdef IFETCH_PERF_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 16'(delivered));
    chk("perf_drop_cnt",  perf_drop_cnt,  16'(drops));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
